exu_lsu: RTL and testbench
==========================

// Module: exu_lsu
// PURPOSE
//  Parametrised load/store unit for the execute stage. Replaces the combinational memory path
//  with an explicit request/response FSM. Adds DW-wide data, byte strobes, registered
//  load-result alignment and extension, a bus timeout with access fault, and pipeline flush
//  with response drain. Sits between the EXU decode outputs and the core's valid/ready data bus.
// PARAMETERS
//  DW           32  data/address width, 32 or 64; DW=64 enables size 3 (ld/sd/lwu)
//  TIMEOUT_CYC  256 max cycles from REQ entry to response; 0 disables timeout
// PORTS
//  clk               in   1      clock
//  rst_n             in   1      reset, asynchronous, active-low
//  req_i             in   1      EXU requests a memory op; held until done_o or flush_i
//  store_i           in   1      1=store, 0=load
//  size_i            in   2      0 byte, 1 half, 2 word, 3 dword
//  unsigned_i        in   1      zero-extend load result (lbu/lhu/lwu)
//  addr_i            in   DW     effective address
//  wdata_i           in   DW     store data (rs2), LSB-aligned
//  flush_i           in   1      pipeline flush; abandon current op
//  misaligned_o      out  1      misaligned or illegal-size access (comb)
//  stall_o           out  1      hold pipeline
//  done_o            out  1      1-cycle pulse: op finished (success or fault)
//  fault_o           out  1      valid with done_o: bus error or timeout
//  reg_we_o          out  1      write rd (load success), valid with done_o
//  reg_wdata_o       out  DW     aligned, extended load data
//  bus_req_valid_o   out  1      bus request valid
//  bus_req_ready_i   in   1      bus accepts request
//  bus_addr_o        out  DW     registered address
//  bus_we_o          out  1      registered write enable
//  bus_strb_o        out  DW/8   registered byte strobes
//  bus_wdata_o       out  DW     registered lane-shifted store data
//  bus_rsp_valid_i   in   1      bus response valid
//  bus_rsp_ready_o   out  1      LSU accepts response
//  bus_rdata_i       in   DW     response data
//  bus_rsp_err_i     in   1      response error
// BEHAVIOUR
//  Reset: state=IDLE; all outputs and registers 0; timeout counter 0.
//  OFF = addr_i[log2(DW/8)-1:0]; N = 1<<size_i bytes.
//  misaligned_o = req_i & IDLE & (OFF % N != 0 | (size_i==3 & DW==32)).
//  misaligned op: no bus activity, no state change; EXU takes trap.
//  Strobe = ((1<<N)-1) << OFF; bus_wdata = wdata_i << (8*OFF).
//  Load data = (rdata >> 8*OFF) truncated to N bytes, sign- or zero-extended to DW.
//  States:
//   IDLE : req_i & ~misaligned & ~flush_i -> capture addr/we/strb/wdata/size/unsigned, go REQ.
//   REQ  : bus_req_valid_o=1; address/data stable until handshake; ready_i -> RSP.
//          flush_i without ready_i -> IDLE (withdraw allowed).
//          flush_i with ready_i -> DRAIN.
//   RSP  : bus_rsp_ready_o=1; rsp_valid_i -> latch aligned rdata and err, go DONE.
//          flush_i -> DRAIN; flush_i and rsp_valid_i in the same cycle -> IDLE, result dropped.
//   DONE : done_o=1 for one cycle; reg_we_o = ~store & ~fault; -> IDLE.
//          A new op is accepted next cycle at the earliest.
//   DRAIN: bus_rsp_ready_o=1; wait rsp_valid_i, discard it, no done_o -> IDLE.
//          Timeout also exits to IDLE.
//  Responses are only accepted in RSP/DRAIN; none expected in the handshake cycle.
//  Timeout: counter clears on REQ entry and counts each REQ/RSP/DRAIN cycle.
//   Count reaches TIMEOUT_CYC-1 with no response -> DONE with fault_o=1, reg_we_o=0.
//   In DRAIN, timeout -> IDLE silently. A late response after timeout is ignored in IDLE.
//  stall_o = req_i & ~misaligned_o & ~flush_i & (state!=DONE); DRAIN with req_i stalls.
//  Minimum latency: request cycle 0 (IDLE), handshake in REQ cycle 1, response cycle 2,
//  done_o cycle 3.
//  Async reset mid-op returns to IDLE immediately; outstanding bus response is not tracked.
// TESTING
//  DW=32 lw @0x1000, ready immediate, rdata 0xDEADBEEF one cycle later
//   -> done_o cycle 3, reg_wdata 0xDEADBEEF, reg_we 1.
//  lb @0x1003, rdata 0x80112233 -> 0xFFFFFF80; lbu same -> 0x00000080.
//  sh @0x1002, wdata 0x1234ABCD -> strb 4'b1100, bus_wdata 0xABCD0000, we 1, reg_we 0.
//  lw @0x1001 -> misaligned_o 1 same cycle, bus_req_valid_o stays 0;
//   DW=32 size 3 -> misaligned_o 1.
//  TIMEOUT_CYC=16, no response -> done_o & fault_o 16 cycles after REQ entry;
//   bus_rsp_err_i=1 -> fault_o 1, reg_we 0.
//  flush_i in RSP -> DRAIN; response arrives 3 cycles later -> discarded, no done_o, then IDLE.
//   DW=64 ld @0x8 -> strb 8'hFF.

Source files
------------

// File: rtl/exu_lsu.sv
// Load/store unit for the execute stage: request/response bus FSM with byte strobes,
// registered load alignment/extension, bus timeout and flush with response drain.
module exu_lsu #(
  parameter int DW          = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_i,
  input  logic            store_i,
  input  logic [1:0]      size_i,
  input  logic            unsigned_i,
  input  logic [DW-1:0]   addr_i,
  input  logic [DW-1:0]   wdata_i,
  input  logic            flush_i,
  output logic            misaligned_o,
  output logic            stall_o,
  output logic            done_o,
  output logic            fault_o,
  output logic            reg_we_o,
  output logic [DW-1:0]   reg_wdata_o,
  output logic            bus_req_valid_o,
  input  logic            bus_req_ready_i,
  output logic [DW-1:0]   bus_addr_o,
  output logic            bus_we_o,
  output logic [DW/8-1:0] bus_strb_o,
  output logic [DW-1:0]   bus_wdata_o,
  input  logic            bus_rsp_valid_i,
  output logic            bus_rsp_ready_o,
  input  logic [DW-1:0]   bus_rdata_i,
  input  logic            bus_rsp_err_i
);

  localparam int SW = DW / 8;
  localparam int OW = $clog2(SW);
  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] REQ   = 3'd1;
  localparam logic [2:0] RSP   = 3'd2;
  localparam logic [2:0] DONE  = 3'd3;
  localparam logic [2:0] DRAIN = 3'd4;

  function automatic logic misalign_f(input logic [OW-1:0] off, input logic [1:0] sz);
    logic m;
    m = (sz == 2'd3) && (DW == 32);
    for (int i = 0; i < OW; i++) m = m | (off[i] & (i < int'(sz)));
    return m;
  endfunction

  function automatic logic [SW-1:0] strb_f(input logic [OW-1:0] off, input logic [1:0] sz);
    logic [SW-1:0] m;
    for (int i = 0; i < SW; i++) m[i] = (i < int'(32'd1 << sz));
    return m << off;
  endfunction

  function automatic logic [DW-1:0] ext_f(input logic [DW-1:0] d, input logic [1:0] sz,
                                          input logic uns);
    logic [DW-1:0] r;
    logic          sgn;
    int            nb;
    nb = int'(32'd8 << sz);
    case (sz)
      2'd0:    sgn = d[7];
      2'd1:    sgn = d[15];
      2'd2:    sgn = d[31];
      default: sgn = d[DW-1];
    endcase
    sgn = sgn & ~uns;
    for (int i = 0; i < DW; i++) r[i] = (i < nb) ? d[i] : sgn;
    return r;
  endfunction

  logic [2:0]    state_r;
  logic [CW-1:0] cnt_r;
  logic [OW-1:0] off_r;
  logic [1:0]    size_r;
  logic          uns_r;
  logic [DW-1:0] addr_r;
  logic          we_r;
  logic [SW-1:0] strb_r;
  logic [DW-1:0] wdata_r;
  logic          fault_r;
  logic          reg_we_r;
  logic [DW-1:0] reg_wdata_r;
  logic [OW-1:0] off_s;
  logic          to_s;
  logic [DW-1:0] rsh_s;

  assign off_s = addr_i[OW-1:0];
  assign to_s  = (TIMEOUT_CYC != 0) && (cnt_r == TO_LAST);
  assign rsh_s = bus_rdata_i >> {off_r, 3'b000};

  assign misaligned_o    = req_i & (state_r == IDLE) & misalign_f(off_s, size_i);
  assign stall_o         = req_i & ~misaligned_o & ~flush_i & (state_r != DONE);
  assign done_o          = (state_r == DONE);
  assign fault_o         = fault_r;
  assign reg_we_o        = reg_we_r;
  assign reg_wdata_o     = reg_wdata_r;
  assign bus_req_valid_o = (state_r == REQ);
  assign bus_rsp_ready_o = (state_r == RSP) | (state_r == DRAIN);
  assign bus_addr_o      = addr_r;
  assign bus_we_o        = we_r;
  assign bus_strb_o      = strb_r;
  assign bus_wdata_o     = wdata_r;

  // Request/response FSM; timeout counter runs in every bus-owning state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      off_r       <= '0;
      size_r      <= 2'd0;
      uns_r       <= 1'b0;
      addr_r      <= '0;
      we_r        <= 1'b0;
      strb_r      <= '0;
      wdata_r     <= '0;
      fault_r     <= 1'b0;
      reg_we_r    <= 1'b0;
      reg_wdata_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_i & ~misaligned_o & ~flush_i) begin
            addr_r  <= addr_i;
            we_r    <= store_i;
            strb_r  <= strb_f(off_s, size_i);
            wdata_r <= wdata_i << {off_s, 3'b000};
            off_r   <= off_s;
            size_r  <= size_i;
            uns_r   <= unsigned_i;
            cnt_r   <= '0;
            state_r <= REQ;
          end
        end
        REQ: begin
          cnt_r <= cnt_r + CW'(1'b1);
          // Timeout wins over a late handshake; any response that follows lands in IDLE.
          if (flush_i) begin
            state_r <= (bus_req_ready_i & ~to_s) ? DRAIN : IDLE;
          end else if (to_s) begin
            fault_r  <= 1'b1;
            reg_we_r <= 1'b0;
            state_r  <= DONE;
          end else if (bus_req_ready_i) begin
            state_r <= RSP;
          end
        end
        RSP: begin
          cnt_r <= cnt_r + CW'(1'b1);
          if (flush_i) begin
            state_r <= (bus_rsp_valid_i | to_s) ? IDLE : DRAIN;
          end else if (bus_rsp_valid_i) begin
            reg_wdata_r <= ext_f(rsh_s, size_r, uns_r);
            fault_r     <= bus_rsp_err_i;
            reg_we_r    <= ~we_r & ~bus_rsp_err_i;
            state_r     <= DONE;
          end else if (to_s) begin
            fault_r  <= 1'b1;
            reg_we_r <= 1'b0;
            state_r  <= DONE;
          end
        end
        DRAIN: begin
          cnt_r <= cnt_r + CW'(1'b1);
          if (bus_rsp_valid_i | to_s) state_r <= IDLE;
        end
        DONE: begin
          fault_r  <= 1'b0;
          reg_we_r <= 1'b0;
          state_r  <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exu_lsu.sv
// Scoreboard bench for exu_lsu: DW=32 instance (TIMEOUT_CYC=16) plus a DW=64 instance.
module tb_exu_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  logic        req = 1'b0, store = 1'b0, uns = 1'b0, flush = 1'b0;
  logic [1:0]  size = 2'd0;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic        misaligned, stall, done, fault, reg_we;
  logic [31:0] reg_wdata;
  logic        breq_valid, breq_ready = 1'b0, bwe, brsp_valid = 1'b0, brsp_ready, brsp_err = 1'b0;
  logic [31:0] baddr, bwdata, brdata = 32'h0;
  logic [3:0]  bstrb;

  logic        q_req = 1'b0, q_uns = 1'b0;
  logic [1:0]  q_size = 2'd0;
  logic [63:0] q_addr = 64'h0;
  logic        q_misaligned, q_stall, q_done, q_fault, q_reg_we;
  logic [63:0] q_reg_wdata, q_baddr, q_bwdata, q_brdata = 64'h0;
  logic        q_breq_valid, q_breq_ready = 1'b0, q_bwe, q_brsp_valid = 1'b0, q_brsp_ready;
  logic [7:0]  q_bstrb;

  logic [68:0] req_q[$];
  logic [33:0] rsp_q[$];
  logic [68:0] e_req;
  logic [33:0] e_rsp;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  exu_lsu #(.DW(32), .TIMEOUT_CYC(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .store_i(store), .size_i(size), .unsigned_i(uns),
    .addr_i(addr), .wdata_i(wdata), .flush_i(flush), .misaligned_o(misaligned), .stall_o(stall),
    .done_o(done), .fault_o(fault), .reg_we_o(reg_we), .reg_wdata_o(reg_wdata),
    .bus_req_valid_o(breq_valid), .bus_req_ready_i(breq_ready), .bus_addr_o(baddr),
    .bus_we_o(bwe), .bus_strb_o(bstrb), .bus_wdata_o(bwdata), .bus_rsp_valid_i(brsp_valid),
    .bus_rsp_ready_o(brsp_ready), .bus_rdata_i(brdata), .bus_rsp_err_i(brsp_err));

  exu_lsu #(.DW(64), .TIMEOUT_CYC(256)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .req_i(q_req), .store_i(1'b0), .size_i(q_size), .unsigned_i(q_uns),
    .addr_i(q_addr), .wdata_i(64'h0), .flush_i(1'b0), .misaligned_o(q_misaligned),
    .stall_o(q_stall), .done_o(q_done), .fault_o(q_fault), .reg_we_o(q_reg_we),
    .reg_wdata_o(q_reg_wdata), .bus_req_valid_o(q_breq_valid), .bus_req_ready_i(q_breq_ready),
    .bus_addr_o(q_baddr), .bus_we_o(q_bwe), .bus_strb_o(q_bstrb), .bus_wdata_o(q_bwdata),
    .bus_rsp_valid_i(q_brsp_valid), .bus_rsp_ready_o(q_brsp_ready), .bus_rdata_i(q_brdata),
    .bus_rsp_err_i(1'b0));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Bus request monitor: every handshake must match the next expected request.
  always @(negedge clk) begin
    if (rst_n && breq_valid && breq_ready) begin
      if (req_q.size() == 0) chk("unexpected_bus_req", 64'd1, 64'd0);
      else begin
        e_req = req_q.pop_front();
        chk("bus_addr", 64'(baddr), 64'(e_req[68:37]));
        chk("bus_we", 64'(bwe), 64'(e_req[36]));
        chk("bus_strb", 64'(bstrb), 64'(e_req[35:32]));
        if (e_req[36]) chk("bus_wdata", 64'(bwdata), 64'(e_req[31:0]));
      end
    end
  end

  // Completion monitor: every done pulse must match the next expected result.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (rsp_q.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
      else begin
        e_rsp = rsp_q.pop_front();
        chk("fault", 64'(fault), 64'(e_rsp[33]));
        chk("reg_we", 64'(reg_we), 64'(e_rsp[32]));
        if (e_rsp[32]) chk("reg_wdata", 64'(reg_wdata), 64'(e_rsp[31:0]));
      end
    end
  end

  task automatic run_op(input logic st, input logic [1:0] sz, input logic un,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                        input logic er, input int dly, input int lat,
                        input logic [3:0] xstrb, input logic [31:0] xbw,
                        input logic xf, input logic xwe, input logic [31:0] xd);
    int t0;
    bit seen;
    req_q.push_back({a, st, xstrb, xbw});
    rsp_q.push_back({xf, xwe, xd});
    @(posedge clk); #1;
    req = 1'b1; store = st; size = sz; uns = un; addr = a; wdata = wd; breq_ready = 1'b1;
    t0 = cyc;
    #1;
    chk("stall_on_req", 64'(stall), 64'd1);
    chk("misaligned_clear", 64'(misaligned), 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    breq_ready = 1'b0;
    if (dly >= 0) begin
      repeat (dly) begin @(posedge clk); #1; end
      brsp_valid = 1'b1; brdata = rd; brsp_err = er;
      @(posedge clk); #1;
      brsp_valid = 1'b0; brsp_err = 1'b0;
    end
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("done_seen", 64'(seen), 64'd1);
    if (seen) chk("latency", 64'(cyc - t0), 64'(lat));
    @(posedge clk); #1;
    req = 1'b0; store = 1'b0;
  endtask

  task automatic run64(input logic [1:0] sz, input logic un, input logic [63:0] a,
                       input logic [63:0] rd, input logic [7:0] xstrb, input logic [63:0] xd);
    @(posedge clk); #1;
    q_req = 1'b1; q_size = sz; q_uns = un; q_addr = a; q_breq_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("valid64", 64'(q_breq_valid), 64'd1);
    chk("strb64", 64'(q_bstrb), 64'(xstrb));
    @(posedge clk); #1;
    q_breq_ready = 1'b0; q_brsp_valid = 1'b1; q_brdata = rd;
    @(posedge clk); #1;
    q_brsp_valid = 1'b0;
    @(negedge clk);
    chk("done64", 64'(q_done), 64'd1);
    chk("reg_wdata64", q_reg_wdata, xd);
    @(posedge clk); #1;
    q_req = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_bus_valid", 64'(breq_valid), 64'd0);
    chk("rst_rsp_ready", 64'(brsp_ready), 64'd0);
    chk("rst_reg_wdata", 64'(reg_wdata), 64'd0);
    chk("rst_strb", 64'(bstrb), 64'd0);
    rst_n = 1'b1;

    // st sz un addr wdata rdata err dly lat strb bwdata fault we data
    run_op(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 32'hDEADBEEF, 1'b0, 0, 3,
           4'hF, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF);
    run_op(1'b0, 2'd0, 1'b0, 32'h1003, 32'h0, 32'h80112233, 1'b0, 0, 3,
           4'b1000, 32'h0, 1'b0, 1'b1, 32'hFFFFFF80);
    run_op(1'b0, 2'd0, 1'b1, 32'h1003, 32'h0, 32'h80112233, 1'b0, 0, 3,
           4'b1000, 32'h0, 1'b0, 1'b1, 32'h00000080);
    run_op(1'b1, 2'd1, 1'b0, 32'h1002, 32'h1234ABCD, 32'h0, 1'b0, 0, 3,
           4'b1100, 32'hABCD0000, 1'b0, 1'b0, 32'h0);
    run_op(1'b0, 2'd1, 1'b0, 32'h1002, 32'h0, 32'h80011234, 1'b0, 2, 5,
           4'b1100, 32'h0, 1'b0, 1'b1, 32'hFFFF8001);
    run_op(1'b1, 2'd0, 1'b0, 32'h1001, 32'h000000A5, 32'h0, 1'b0, 0, 3,
           4'b0010, 32'h0000A500, 1'b0, 1'b0, 32'h0);
    run_op(1'b0, 2'd2, 1'b0, 32'h2000, 32'h0, 32'h12345678, 1'b1, 0, 3,
           4'hF, 32'h0, 1'b1, 1'b0, 32'h0);
    run_op(1'b0, 2'd2, 1'b0, 32'h3000, 32'h0, 32'h0, 1'b0, -1, 17,
           4'hF, 32'h0, 1'b1, 1'b0, 32'h0);

    // Misaligned word and illegal dword on DW=32: trap, no bus activity.
    @(posedge clk); #1;
    req = 1'b1; size = 2'd2; addr = 32'h1001;
    #1;
    chk("misaligned_lw", 64'(misaligned), 64'd1);
    chk("no_stall_misaligned", 64'(stall), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_bus_misaligned", 64'(breq_valid), 64'd0);
    end
    size = 2'd3; addr = 32'h1000;
    #1;
    chk("misaligned_dword32", 64'(misaligned), 64'd1);
    @(negedge clk);
    chk("no_bus_dword32", 64'(breq_valid), 64'd0);
    @(posedge clk); #1;
    req = 1'b0; size = 2'd0;

    // Flush in RSP: response arrives three cycles later and is swallowed.
    req_q.push_back({32'h1000, 1'b0, 4'hF, 32'h0});
    @(posedge clk); #1;
    req = 1'b1; size = 2'd2; addr = 32'h1000; breq_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    breq_ready = 1'b0; flush = 1'b1; req = 1'b0;
    @(negedge clk);
    chk("rsp_ready_in_rsp", 64'(brsp_ready), 64'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("rsp_ready_in_drain", 64'(brsp_ready), 64'd1);
    chk("no_done_drain", 64'(done), 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    brsp_valid = 1'b1; brdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    brsp_valid = 1'b0;
    @(negedge clk);
    chk("idle_after_drain", 64'(brsp_ready), 64'd0);
    chk("no_done_after_drain", 64'(done), 64'd0);

    run_op(1'b0, 2'd2, 1'b0, 32'h4004, 32'h0, 32'h0BADF00D, 1'b0, 0, 3,
           4'hF, 32'h0, 1'b0, 1'b1, 32'h0BADF00D);

    run64(2'd3, 1'b0, 64'h8, 64'h8877665544332211, 8'hFF, 64'h8877665544332211);
    run64(2'd2, 1'b0, 64'h4, 64'h80000000_11111111, 8'hF0, 64'hFFFFFFFF_80000000);
    run64(2'd2, 1'b1, 64'h4, 64'h80000000_11111111, 8'hF0, 64'h00000000_80000000);

    repeat (3) @(negedge clk);
    chk("req_queue_empty", 64'(req_q.size()), 64'd0);
    chk("rsp_queue_empty", 64'(rsp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
